// File: rtl/decode_operand_stage.sv
// Decode and operand-fetch stage feeding the 16-bit ALU. The stage reads a register file
// with writeback bypass, interlocks RAW/WAW hazards with a busy scoreboard, and holds one output entry.
module decode_operand_stage #(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [3:0]    Imm,
    output logic [1:0]    Alu_Control,
    output logic [3:0]    out_rd,
    input  logic          wb_en,
    input  logic [3:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          err_illegal
);
    logic [DW-1:0]    r_rf [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_out_valid;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [3:0]       r_imm;
    logic [1:0]       r_alu;
    logic [3:0]       r_rd;
    logic             r_err;

    logic [3:0]       w_op, w_rd, w_rs, w_rt;
    logic             w_legal, w_regreg, w_hazard, w_accept;
    logic [NREGS-1:0] w_wb_clr, w_busy_eff, w_busy_set;
    logic [DW-1:0]    w_rs_val, w_rt_val;

    assign w_op     = in_instr[15:12];
    assign w_rd     = in_instr[11:8];
    assign w_rs     = in_instr[7:4];
    assign w_rt     = in_instr[3:0];
    assign w_legal  = (w_op[3:2] == 2'b00);
    assign w_regreg = w_legal && !w_op[0];

    always_comb begin
        w_wb_clr = '0;
        if (wb_en && wb_addr != 4'd0)
            w_wb_clr[wb_addr] = 1'b1;
    end

    assign w_busy_eff = r_busy & ~w_wb_clr;

    // Source reads see a same-cycle writeback so a stalled consumer issues on the wb edge
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs != 4'd0)
            w_rs_val = (wb_en && wb_addr == w_rs) ? wb_data : r_rf[w_rs];
        if (w_rt != 4'd0)
            w_rt_val = (wb_en && wb_addr == w_rt) ? wb_data : r_rf[w_rt];
    end

    assign w_hazard = w_legal && (w_busy_eff[w_rs] || w_busy_eff[w_rd] ||
                                  (w_regreg && w_busy_eff[w_rt]));
    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_busy_set = '0;
        if (w_accept && w_legal && w_rd != 4'd0)
            w_busy_set[w_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_rf[i] <= '0;
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_alu       <= '0;
            r_rd        <= '0;
            r_err       <= 1'b0;
        end else begin
            if (wb_en && wb_addr != 4'd0)
                r_rf[wb_addr] <= wb_data;
            r_busy <= (r_busy & ~w_wb_clr) | w_busy_set;
            if (w_accept && w_legal) begin
                r_out_valid <= 1'b1;
                r_a         <= w_rs_val;
                r_b         <= w_regreg ? w_rt_val : '0;
                r_imm       <= w_rt;
                r_alu       <= {w_op[0], w_op[1]};
                r_rd        <= w_rd;
            end else if (w_accept || out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !w_legal)
                r_err <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign a           = r_a;
    assign b           = r_b;
    assign Imm         = r_imm;
    assign Alu_Control = r_alu;
    assign out_rd      = r_rd;
    assign err_illegal = r_err;
endmodule

// File: tb/tb_decode_operand_stage.sv
// Self-checking bench for decode_operand_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level instruction model of the stage.
module tb_decode_operand_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a, b;
    logic [3:0]  Imm;
    logic [1:0]  Alu_Control;
    logic [3:0]  out_rd;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err_illegal;

    decode_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .Imm(Imm), .Alu_Control(Alu_Control), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference state: architectural registers, pending-writer flags and the output entry
    int unsigned m_rf [16];
    bit          m_busy [16];
    bit          m_ov, m_err;
    int unsigned m_a, m_b, m_imm, m_alu, m_rd;

    function automatic bit pending(int idx, bit we, int wa);
        return idx != 0 && m_busy[idx] && !(we && wa == idx);
    endfunction

    function automatic int unsigned rd_reg(int idx, bit we, int wa, int unsigned wd);
        if (idx == 0) return 0;
        if (we && wa == idx) return wd;
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
        m_ov = 0; m_err = 0; m_a = 0; m_b = 0; m_imm = 0; m_alu = 0; m_rd = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        chk({tag, ".a"}, a, m_a);
        chk({tag, ".b"}, b, m_b);
        chk({tag, ".Imm"}, Imm, m_imm);
        chk({tag, ".alu"}, Alu_Control, m_alu);
        chk({tag, ".rd"}, out_rd, m_rd);
        chk({tag, ".err"}, err_illegal, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; in_valid = 0; in_instr = 16'h0000; out_ready = 1;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        check_outputs("reset");
        chk("reset.in_ready", in_ready, 1);
    endtask

    // One clock: drive, check in_ready, clock, advance model, check registered outputs
    task automatic step(input string tag, input bit v, input logic [15:0] ins, input bit ordy,
                        input bit we, input logic [3:0] wa, input logic [15:0] wd);
        int op, rd, rs, rt;
        bit legal, rr, haz, rdy, acc;
        int unsigned va, vb;
        @(negedge clk);
        in_valid = v; in_instr = ins; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        op = int'(ins[15:12]); rd = int'(ins[11:8]); rs = int'(ins[7:4]); rt = int'(ins[3:0]);
        legal = op < 4;
        rr = (op == 0) || (op == 2);
        haz = legal && (pending(rs, we, wa) || pending(rd, we, wa) || (rr && pending(rt, we, wa)));
        rdy = (!m_ov || ordy) && !haz;
        acc = v && rdy;
        va = rd_reg(rs, we, wa, wd);
        vb = rr ? rd_reg(rt, we, wa, wd) : 0;
        #1;
        chk({tag, ".in_ready"}, in_ready, rdy);
        @(posedge clk);
        if (acc && legal) begin
            m_ov = 1; m_a = va; m_b = vb; m_imm = rt; m_rd = rd;
            case (op)
                0: m_alu = 2'b00;
                1: m_alu = 2'b10;
                2: m_alu = 2'b01;
                default: m_alu = 2'b11;
            endcase
        end else if (acc) begin
            m_ov = 0; m_err = 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (we && wa != 0) begin m_rf[wa] = wd; m_busy[wa] = 0; end
        if (acc && legal && rd != 0) m_busy[rd] = 1;
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [15:0] ins_of(int op, int rd, int rs, int rt);
        return {op[3:0], rd[3:0], rs[3:0], rt[3:0]};
    endfunction

    initial begin
        reset = 1; in_valid = 0; in_instr = 0; out_ready = 1;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        do_reset();

        // R1..R15 all read zero after reset
        for (int r = 1; r < 16; r++) begin
            step("rdzero", 1, ins_of(0, 0, r, r), 1, 0, 0, 0);
            chk("rdzero.a_const", a, 0);
        end

        step("wbR2", 0, 0, 1, 1, 2, 16'h0005);
        step("add", 1, ins_of(2, 3, 2, 2), 1, 0, 0, 0);
        chk("add.a_const", a, 16'h0005);
        chk("add.b_const", b, 16'h0005);
        chk("add.alu_const", Alu_Control, 2'b01);
        chk("add.rd_const", out_rd, 3);

        step("addi_stall", 1, ins_of(3, 4, 3, 15), 1, 0, 0, 0);
        chk("addi_stall.vld_const", out_valid, 0);
        step("addi_byp", 1, ins_of(3, 4, 3, 15), 1, 1, 3, 16'h0009);
        chk("addi_byp.a_const", a, 16'h0009);
        chk("addi_byp.imm_const", Imm, 4'hF);
        chk("addi_byp.alu_const", Alu_Control, 2'b11);

        step("wbR4", 0, 0, 1, 1, 4, 16'h1234);
        step("andi", 1, ins_of(1, 5, 2, 7), 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step("hold", 1, ins_of(0, 6, 2, 2), 0, 0, 0, 0);
        chk("hold.imm_const", Imm, 4'h7);
        step("release", 1, ins_of(0, 6, 2, 2), 1, 0, 0, 0);
        chk("release.rd_const", out_rd, 6);

        step("illegal", 1, 16'h7123, 1, 0, 0, 0);
        chk("illegal.err_const", err_illegal, 1);
        step("illegal_busy5", 1, ins_of(1, 0, 5, 0), 1, 0, 0, 0);
        do_reset();

        step("r0", 1, ins_of(0, 0, 0, 0), 1, 1, 0, 16'hFFFF);
        chk("r0.a_const", a, 0);
        step("r0_nostall", 1, ins_of(2, 0, 0, 0), 1, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            int op, sel;
            logic [15:0] ins;
            sel = int'($urandom_range(0, 7));
            op = (sel == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            ins = ins_of(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 15)) & ((op == 0 || op == 2) ? 7 : 15));
            step("rand", $urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), 16'($urandom));
            if (n == 300) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
